// File: rtl/mux_nx1_rr_stream.sv
// N-to-1 registered stream multiplexer with fixed-select or round-robin arbitration.
// Each input channel uses a valid/ready handshake. The selected word goes into a
// one-entry output register that honours out_ready backpressure.
// Optional build macro MUX_STATS_EN adds the xfer_cnt port, a saturating 16-bit
// count of accepted output words.
module mux_nx1_rr_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
`ifdef MUX_STATS_EN
  output logic [15:0]        xfer_cnt,
`endif
  input  logic               out_ready
);

  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_chan;
  logic             r_valid;
  logic [SELW-1:0]  r_rr_ptr;

  logic             w_load;
  logic             w_gnt_any;
  logic [SELW-1:0]  w_gnt_idx;
  logic [N-1:0]     w_grant;
  logic             w_xfer;
  logic [WIDTH-1:0] w_gnt_data;

  // The register can take a new word when it is empty or being drained this cycle.
  assign w_load = !r_valid | out_ready;

  // Grant selection: direct select in fixed mode, rotating scan after rr_ptr otherwise.
  always_comb begin
    int unsigned idx;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    idx       = 0;
    if (!mode) begin
      // Out-of-range select (possible when N is not a power of two) grants nothing.
      if (32'(sel) < N && in_valid[sel]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = sel;
      end
    end else begin
      for (int unsigned k = 1; k <= N; k++) begin
        idx = (32'(r_rr_ptr) + k) % N;
        if (!w_gnt_any && in_valid[idx]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = SELW'(idx);
        end
      end
    end
  end

  assign w_grant    = w_gnt_any ? (N'(1) << w_gnt_idx) : '0;
  // Ready is held low during reset even though the empty register would otherwise load.
  assign in_ready   = w_grant & {N{w_load & rst_n}};
  assign w_xfer     = w_gnt_any & w_load;
  assign w_gnt_data = in_data[32'(w_gnt_idx)*WIDTH +: WIDTH];

  // Output register and round-robin pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data   <= '0;
      r_chan   <= '0;
      r_valid  <= 1'b0;
      r_rr_ptr <= SELW'(N - 1);
    end else if (w_xfer) begin
      r_data  <= w_gnt_data;
      r_chan  <= w_gnt_idx;
      r_valid <= 1'b1;
      if (mode) begin
        r_rr_ptr <= w_gnt_idx;
      end
    end else if (out_ready) begin
      // Drained with nothing to refill; data and channel keep their last values.
      r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_chan  = r_chan;
  assign out_valid = r_valid;

`ifdef MUX_STATS_EN
  logic [15:0] r_xfer_cnt;

  // Count accepted output words, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_cnt <= '0;
    end else if (r_valid && out_ready && r_xfer_cnt != 16'hFFFF) begin
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_mux_nx1_rr_stream.sv
// Directed self-checking bench for mux_nx1_rr_stream (N=4 main instance plus an
// N=5 instance for out-of-range select). Define MUX_STATS_EN to also check xfer_cnt.
module tb_mux_nx1_rr_stream;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  logic [39:0] in_data5;
  logic [4:0]  in_valid5;
  logic [4:0]  in_ready5;
  logic [2:0]  sel5;
  logic [7:0]  out_data5;
  logic [2:0]  out_chan5;
  logic        out_valid5;

`ifdef MUX_STATS_EN
  logic [15:0] xfer_cnt;
  logic [15:0] xfer_cnt5;
`endif

  int total = 0;
  int bad   = 0;

  mux_nx1_rr_stream #(.WIDTH(8), .N(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
`ifdef MUX_STATS_EN
    .xfer_cnt  (xfer_cnt),
`endif
    .out_ready (out_ready)
  );

  mux_nx1_rr_stream #(.WIDTH(8), .N(5)) u_dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data5),
    .in_valid  (in_valid5),
    .in_ready  (in_ready5),
    .mode      (1'b0),
    .sel       (sel5),
    .out_data  (out_data5),
    .out_chan  (out_chan5),
    .out_valid (out_valid5),
`ifdef MUX_STATS_EN
    .xfer_cnt  (xfer_cnt5),
`endif
    .out_ready (1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with arbitrary active inputs.
    rst_n     = 1'b0;
    in_data   = 32'hDEADBEEF;
    in_valid  = 4'b1111;
    mode      = 1'b1;
    sel       = 2'd1;
    out_ready = 1'b1;
    in_data5  = 40'h5544332211;
    in_valid5 = 5'b11111;
    sel5      = 3'd5;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'h00);
    check("rst_out_chan",  32'(out_chan),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'h0);
    in_valid = 4'b0000;
    rst_n    = 1'b1;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'h0);

    // N=5: select 5 is out of range, select 4 is valid.
    check("sel5_oor_ready", 32'(in_ready5), 32'h00);
    sel5 = 3'd4;
    #1;
    check("sel4_ready", 32'(in_ready5), 32'h10);

    // Fixed select of channel 2.
    step();
    mode    = 1'b0;
    sel     = 2'd2;
    in_data = 32'h44C32211;
    in_valid = 4'b1111;
    #1;
    check("fix_in_ready", 32'(in_ready), 32'b0100);
    step();
    check("fix_out_data",  32'(out_data),  32'hC3);
    check("fix_out_chan",  32'(out_chan),  32'd2);
    check("fix_out_valid", 32'(out_valid), 32'd1);
    in_valid = 4'b0000;
    step();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_data",  32'(out_data),  32'hC3);
    check("drain_chan",  32'(out_chan),  32'd2);

    // Round-robin, all valid; fixed-mode transfers left rr_ptr at 3.
    mode     = 1'b1;
    in_data  = 32'h40302010;
    in_valid = 4'b1111;
    #1;
    check("rr_first_ready", 32'(in_ready), 32'b0001);
    for (int i = 0; i < 8; i++) begin
      step();
      check("rr_chan",  32'(out_chan),  32'(i % 4));
      check("rr_data",  32'(out_data),  32'((i % 4 + 1) * 16));
      check("rr_valid", 32'(out_valid), 32'd1);
    end

    // Sparse round-robin from rr_ptr=3: expect 1, 3, 1.
    in_valid = 4'b1010;
    step();
    check("sparse_chan_a", 32'(out_chan), 32'd1);
    check("sparse_data_a", 32'(out_data), 32'h20);
    step();
    check("sparse_chan_b", 32'(out_chan), 32'd3);
    check("sparse_data_b", 32'(out_data), 32'h40);
    step();
    check("sparse_chan_c", 32'(out_chan), 32'd1);
    check("sparse_data_c", 32'(out_data), 32'h20);

    // Backpressure while holding 0x20 from channel 1.
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    #1;
    check("bp_in_ready0", 32'(in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_data",     32'(out_data),  32'h20);
      check("bp_chan",     32'(out_chan),  32'd1);
      check("bp_valid",    32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready),  32'h0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'b0100);
    step();
    check("post_bp_chan_a", 32'(out_chan), 32'd2);
    check("post_bp_data_a", 32'(out_data), 32'h30);
    step();
    check("post_bp_chan_b", 32'(out_chan), 32'd3);
    check("post_bp_data_b", 32'(out_data), 32'h40);
    step();
    check("post_bp_chan_c", 32'(out_chan), 32'd0);
    check("post_bp_data_c", 32'(out_data), 32'h10);

    // Asynchronous reset mid-stream, away from any clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid",    32'(out_valid), 32'd0);
    check("arst_data",     32'(out_data),  32'h00);
    check("arst_chan",     32'(out_chan),  32'd0);
    check("arst_in_ready", 32'(in_ready),  32'h0);
`ifdef MUX_STATS_EN
    check("arst_cnt", 32'(xfer_cnt), 32'd0);
`endif
    #1;
    rst_n = 1'b1;
    #1;
    check("arst_rr_first", 32'(in_ready), 32'b0001);
    step();
    check("arst_first_chan", 32'(out_chan), 32'd0);

`ifdef MUX_STATS_EN
    // Edges so far since release: 1; accepts start on the second edge.
    repeat (4) step();
    check("cnt_small", 32'(xfer_cnt), 32'd4);
    repeat (70000) @(posedge clk);
    #1;
    check("cnt_sat", 32'(xfer_cnt), 32'hFFFF);
    step();
    check("cnt_sat_hold", 32'(xfer_cnt), 32'hFFFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("cnt_reset", 32'(xfer_cnt), 32'd0);
    #1;
    rst_n = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
